// File: rtl/config_readback_tx.sv
// Word-to-byte transmitter for the USB CDC IN path.
// 32-bit readback/status words are buffered in a small word FIFO. Each word is
// sent as 4 bytes on an 8-bit valid/ready stream. A header byte goes out before
// the first word of every frame of FRAME_WORDS words so the host can resync.
//
// Ports:
//   clk_i         system clock
//   reset_i       asynchronous active-high reset
//   word_data_i   word to transmit
//   word_valid_i  word_data_i is valid
//   word_ready_o  FIFO can accept a word (not full)
//   in_data_o     byte to the CDC IN stream
//   in_valid_o    in_data_o is valid
//   in_ready_i    CDC accepts the byte
//   flush_i       close the current partial frame (only while idle and empty)
//   frame_done_o  one-cycle pulse when a frame ends (last byte accepted or flush)
//   busy_o        FIFO non-empty or byte machine not idle
module config_readback_tx #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned FRAME_WORDS = 16,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] word_data_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  input  logic        flush_i,
  output logic        frame_done_o,
  output logic        busy_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt  = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] OneCnt   = CntW'(1);
  localparam logic [7:0]      LastWord = 8'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StHeader, StByte} state_e;

  state_e          state_q, state_d;
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [7:0]      wif_q, wif_d;

  logic        fifo_empty, fifo_full;
  logic        push, pop, frame_wrap, flush_ok;
  logic [31:0] head_word;
  logic [1:0]  byte_sel;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FullCnt);
  assign push       = word_valid_i && !fifo_full;
  // Last byte of the head word leaves; the word is retired from the FIFO.
  assign pop        = (state_q == StByte) && in_ready_i && (byte_idx_q == 2'd3);
  assign frame_wrap = (wif_q == LastWord);
  assign flush_ok   = flush_i && (state_q == StIdle) && fifo_empty && (wif_q != '0);

  assign head_word = mem_q[rd_ptr_q];
  assign byte_sel  = MSB_FIRST ? (2'd3 - byte_idx_q) : byte_idx_q;

  // Word storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= word_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      byte_idx_q <= '0;
      wif_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      wif_q      <= wif_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    wif_d      = wif_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d    = (wif_q == '0) ? StHeader : StByte;
          byte_idx_d = '0;
        end else if (flush_ok) begin
          wif_d = '0;
        end
      end
      StHeader: begin
        if (in_ready_i) begin
          state_d    = StByte;
          byte_idx_d = '0;
        end
      end
      StByte: begin
        if (in_ready_i) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
          end else begin
            byte_idx_d = '0;
            wif_d      = frame_wrap ? 8'd0 : wif_q + 8'd1;
            // Decide on the pre-pop count so back-to-back words have no bubble.
            if (count_q > OneCnt) begin
              state_d = frame_wrap ? StHeader : StByte;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: valid/data decode from registered state only.
  always_comb begin
    in_valid_o = 1'b0;
    in_data_o  = 8'h00;
    unique case (state_q)
      StHeader: begin
        in_valid_o = 1'b1;
        in_data_o  = HEADER_BYTE;
      end
      StByte: begin
        in_valid_o = 1'b1;
        in_data_o  = head_word[{byte_sel, 3'b000} +: 8];
      end
      default: begin
        in_valid_o = 1'b0;
        in_data_o  = 8'h00;
      end
    endcase
  end

  assign word_ready_o = !fifo_full;
  assign frame_done_o = (pop && frame_wrap) || flush_ok;
  assign busy_o       = !fifo_empty || (state_q != StIdle);

endmodule
